// File: rtl/row_max_subtract_pkg.sv
// Shared types and defaults for the softmax row-max subtract stage.
package softmax_pkg;
  localparam int D_W_DEF     = 32;
  localparam int ROW_LEN_DEF = 128;
  localparam int IDX_W       = $clog2(ROW_LEN_DEF);

  typedef enum logic {FILL, DRAIN} state_t;

  typedef logic signed [D_W_DEF-1:0] score_t;
  typedef logic signed [D_W_DEF:0]   norm_t;
endpackage

// File: rtl/row_max_subtract_if.sv
// Score-in / normalized-out stream bundle; master is the environment, slave the stage.
interface row_max_subtract_if
  import softmax_pkg::*;
#(
  parameter int D_W = D_W_DEF
);
  logic           s_valid;
  logic           s_ready;
  logic [D_W-1:0] s_data;
  logic           s_last;
  logic           m_valid;
  logic           m_ready;
  logic [D_W:0]   m_data;
  logic           m_last;
  logic [D_W-1:0] row_max;
  logic           len_err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, row_max, len_err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, row_max, len_err
  );
endinterface

// File: rtl/row_max_subtract_max.sv
// Running signed maximum; initialize loads the sample instead of comparing.
module max
  import softmax_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_init,
  input  logic                  i_vld,
  input  logic signed [D_W-1:0] i_dat,
  output logic signed [D_W-1:0] o_max
);
  logic signed [D_W-1:0] r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max <= '0;
    end else if (i_en && i_vld) begin
      if (i_init || (i_dat > r_max)) begin
        r_max <= i_dat;
      end
    end
  end

  assign o_max = r_max;
endmodule

// File: rtl/row_max_subtract.sv
// Buffers one row of signed scores, then replays it as x - row_max (always <= 0).
// Rows never overlap: input is refused for the whole drain.
module row_max_subtract
  import softmax_pkg::*;
#(
  parameter int D_W     = D_W_DEF,
  parameter int ROW_LEN = ROW_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  row_max_subtract_if.slave  io
);
  localparam int IW = $clog2(ROW_LEN);
  localparam int CW = IW + 1;

  state_t                r_state;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         r_len;
  logic                  r_len_err;
  logic signed [D_W-1:0] r_buf [ROW_LEN];

  logic                  w_s_hs;
  logic                  w_m_hs;
  logic                  w_full;
  logic                  w_row_end;
  logic                  w_rd_last;
  logic signed [D_W-1:0] w_rd_dat;
  logic signed [D_W-1:0] w_max;
  logic signed [D_W:0]   w_diff;

  assign w_s_hs    = io.s_valid && (r_state == FILL);
  assign w_m_hs    = (r_state == DRAIN) && io.m_ready;
  assign w_full    = (r_wr_cnt == CW'(ROW_LEN - 1));
  assign w_row_end = w_s_hs && (io.s_last || w_full);
  assign w_rd_last = (r_rd_cnt == (r_len - CW'(1)));

  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_buf[r_wr_cnt[IW-1:0]] <= io.s_data;
    end
  end

  assign w_rd_dat = r_buf[r_rd_cnt[IW-1:0]];

  max #(.D_W(D_W)) u_max (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == FILL),
    .i_init (r_wr_cnt == '0),
    .i_vld  (w_s_hs),
    .i_dat  (io.s_data),
    .o_max  (w_max)
  );

  // One extra bit of headroom so the full score range never wraps.
  assign w_diff = {w_rd_dat[D_W-1], w_rd_dat} - {w_max[D_W-1], w_max};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_s_hs && w_full && !io.s_last;
      case (r_state)
        FILL: begin
          if (w_s_hs) begin
            r_wr_cnt <= r_wr_cnt + CW'(1);
            if (w_row_end) begin
              r_len    <= r_wr_cnt + CW'(1);
              r_rd_cnt <= '0;
              r_state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_m_hs) begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_rd_last) begin
              r_wr_cnt <= '0;
              r_state  <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign io.s_ready = (r_state == FILL);
  assign io.m_valid = (r_state == DRAIN);
  assign io.m_data  = (r_state == DRAIN) ? w_diff : '0;
  assign io.m_last  = (r_state == DRAIN) && w_rd_last;
  assign io.row_max = w_max;
  assign io.len_err = r_len_err;
endmodule
